// File: rtl/hazard_ctrl_pkg.sv
// Shared types for the hazard controller: bypass select encodings and multicycle FSM states.
package hazard_pkg;

  typedef enum logic [1:0] {
    BYP_FILE   = 2'b00,
    BYP_EX     = 2'b01,
    BYP_MM_PRO = 2'b10,
    BYP_MM_MEM = 2'b11
  } bypass_sel_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_BUSY = 2'd1,
    MD_WB   = 2'd2
  } md_state_e;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard controller bundle; the pipeline is the master, hazard_ctrl the slave.
interface hazard_ctrl_if #(
  parameter int REG_NUM = 32
);
  localparam int RW = $clog2(REG_NUM);

  logic          id_valid;
  logic [RW-1:0] id_rs1;
  logic [RW-1:0] id_rs2;
  logic          id_rs1_used;
  logic          id_rs2_used;
  logic [RW-1:0] id_rd;
  logic          id_is_md;
  logic [RW-1:0] ex_rd;
  logic [RW-1:0] mm_rd;
  logic          ex_wr_reg_en;
  logic          mm_wr_reg_en;
  logic          ex_is_load;
  logic          mm_is_load;
  logic          ex_branch_taken;

  logic [1:0]    rs1_bypass_sel;
  logic [1:0]    rs2_bypass_sel;
  logic          stall_if;
  logic          stall_id;
  logic          flush_id;
  logic          flush_ex;
  logic          md_issue;
  logic          md_busy;
  logic          md_wb_valid;
  logic [RW-1:0] md_wb_rd;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd, id_is_md,
           ex_rd, mm_rd, ex_wr_reg_en, mm_wr_reg_en, ex_is_load, mm_is_load,
           ex_branch_taken,
    input  rs1_bypass_sel, rs2_bypass_sel, stall_if, stall_id, flush_id, flush_ex,
           md_issue, md_busy, md_wb_valid, md_wb_rd
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd, id_is_md,
           ex_rd, mm_rd, ex_wr_reg_en, mm_wr_reg_en, ex_is_load, mm_is_load,
           ex_branch_taken,
    output rs1_bypass_sel, rs2_bypass_sel, stall_if, stall_id, flush_id, flush_ex,
           md_issue, md_busy, md_wb_valid, md_wb_rd
  );

endinterface

// File: rtl/hazard_ctrl_scoreboard.sv
// One pending bit per architectural register for results owed by the multicycle unit.
// Register 0 is hardwired and never marked pending.
module hazard_scoreboard #(
  parameter int REG_NUM = 32,
  parameter int RW      = $clog2(REG_NUM)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_set_en,
  input  logic [RW-1:0] i_set_idx,
  input  logic          i_clr_en,
  input  logic [RW-1:0] i_clr_idx,
  input  logic [RW-1:0] i_rs1,
  input  logic [RW-1:0] i_rs2,
  input  logic [RW-1:0] i_rd,
  output logic          o_rs1_pend,
  output logic          o_rs2_pend,
  output logic          o_rd_pend
);

  logic [REG_NUM-1:0] r_pend;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend <= '0;
    end else begin
      if (i_clr_en) r_pend[i_clr_idx] <= 1'b0;
      if (i_set_en) r_pend[i_set_idx] <= 1'b1;
      r_pend[0] <= 1'b0;
    end
  end

  assign o_rs1_pend = r_pend[i_rs1];
  assign o_rs2_pend = r_pend[i_rs2];
  assign o_rd_pend  = r_pend[i_rd];

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller: ID bypass selects, load-use / scoreboard / structural stalls, branch flushes.
// Define HAZARD_CTRL_MD_EN to build the multicycle-unit scoreboard and sequencing FSM.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_NUM    = 32,
  parameter int MD_LATENCY = 4
) (
  input  logic          clk,
  input  logic          rst,
  hazard_ctrl_if.slave  hz
);

  localparam int RW = $clog2(REG_NUM);

  function automatic bypass_sel_e f_bypass(
    input logic [RW-1:0] s,
    input logic [RW-1:0] ex_rd,
    input logic [RW-1:0] mm_rd,
    input logic          ex_wr,
    input logic          ex_ld,
    input logic          mm_wr,
    input logic          mm_ld
  );
    bypass_sel_e sel;
    sel = BYP_FILE;
    if (s != '0) begin
      // A load in EX has no data yet, so it never bypasses; load-use stall covers it.
      if (ex_wr && (ex_rd == s) && !ex_ld) sel = BYP_EX;
      else if (mm_wr && (mm_rd == s))      sel = mm_ld ? BYP_MM_MEM : BYP_MM_PRO;
    end
    return sel;
  endfunction

  logic w_rs1_lu;
  logic w_rs2_lu;
  logic w_load_use;
  logic w_sb_stall;
  logic w_struct_stall;
  logic w_stall_any;
  logic w_md_issue;

  assign hz.rs1_bypass_sel = f_bypass(hz.id_rs1, hz.ex_rd, hz.mm_rd, hz.ex_wr_reg_en,
                                      hz.ex_is_load, hz.mm_wr_reg_en, hz.mm_is_load);
  assign hz.rs2_bypass_sel = f_bypass(hz.id_rs2, hz.ex_rd, hz.mm_rd, hz.ex_wr_reg_en,
                                      hz.ex_is_load, hz.mm_wr_reg_en, hz.mm_is_load);

  assign w_rs1_lu = hz.id_rs1_used && (hz.id_rs1 != '0) && (hz.ex_rd == hz.id_rs1);
  assign w_rs2_lu = hz.id_rs2_used && (hz.id_rs2 != '0) && (hz.ex_rd == hz.id_rs2);
  assign w_load_use = hz.id_valid && hz.ex_wr_reg_en && hz.ex_is_load && (w_rs1_lu || w_rs2_lu);

`ifdef HAZARD_CTRL_MD_EN
  localparam int CW = (MD_LATENCY > 1) ? $clog2(MD_LATENCY) : 1;

  md_state_e     r_state;
  logic [CW-1:0] r_cnt;
  logic [RW-1:0] r_md_wb_rd;
  logic          r_md_busy;
  logic          r_md_wb_valid;
  logic          w_rs1_pend;
  logic          w_rs2_pend;
  logic          w_rd_pend;

  hazard_scoreboard #(
    .REG_NUM (REG_NUM),
    .RW      (RW)
  ) u_sb (
    .clk        (clk),
    .rst        (rst),
    .i_set_en   (w_md_issue && (hz.id_rd != '0)),
    .i_set_idx  (hz.id_rd),
    .i_clr_en   (r_md_wb_valid),
    .i_clr_idx  (r_md_wb_rd),
    .i_rs1      (hz.id_rs1),
    .i_rs2      (hz.id_rs2),
    .i_rd       (hz.id_rd),
    .o_rs1_pend (w_rs1_pend),
    .o_rs2_pend (w_rs2_pend),
    .o_rd_pend  (w_rd_pend)
  );

  // WAW on a pending rd stalls even if the ID instruction does not write.
  assign w_sb_stall = hz.id_valid && ((hz.id_rs1_used && w_rs1_pend) ||
                                      (hz.id_rs2_used && w_rs2_pend) || w_rd_pend);
  assign w_struct_stall = hz.id_valid && hz.id_is_md && (r_state != MD_IDLE);
  assign w_md_issue = hz.id_valid && hz.id_is_md && !w_stall_any && !hz.ex_branch_taken;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= MD_IDLE;
      r_cnt         <= '0;
      r_md_wb_rd    <= '0;
      r_md_busy     <= 1'b0;
      r_md_wb_valid <= 1'b0;
    end else begin
      case (r_state)
        MD_IDLE: begin
          if (w_md_issue) begin
            r_state    <= MD_BUSY;
            r_cnt      <= CW'(MD_LATENCY - 1);
            r_md_wb_rd <= hz.id_rd;
            r_md_busy  <= 1'b1;
          end
        end
        MD_BUSY: begin
          if (r_cnt == '0) begin
            r_state       <= MD_WB;
            r_md_wb_valid <= 1'b1;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        MD_WB: begin
          r_state       <= MD_IDLE;
          r_md_wb_valid <= 1'b0;
          r_md_busy     <= 1'b0;
        end
        default: begin
          r_state       <= MD_IDLE;
          r_md_wb_valid <= 1'b0;
          r_md_busy     <= 1'b0;
        end
      endcase
    end
  end

  assign hz.md_issue    = w_md_issue;
  assign hz.md_busy     = r_md_busy;
  assign hz.md_wb_valid = r_md_wb_valid;
  assign hz.md_wb_rd    = r_md_wb_rd;
`else
  logic w_unused_md;

  assign w_unused_md    = ^{clk, rst, hz.id_is_md, hz.id_rd, MD_LATENCY[0]};
  assign w_sb_stall     = 1'b0;
  assign w_struct_stall = 1'b0;
  assign w_md_issue     = 1'b0;
  assign hz.md_issue    = 1'b0;
  assign hz.md_busy     = 1'b0;
  assign hz.md_wb_valid = 1'b0;
  assign hz.md_wb_rd    = '0;
`endif

  assign w_stall_any = w_load_use || w_sb_stall || w_struct_stall;

  // A taken branch squashes ID, so any stall it would have caused is moot.
  assign hz.stall_if = w_stall_any && !hz.ex_branch_taken;
  assign hz.stall_id = w_stall_any && !hz.ex_branch_taken;
  assign hz.flush_id = hz.ex_branch_taken;
  assign hz.flush_ex = w_stall_any || hz.ex_branch_taken;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: expectations are queued as stimulus is driven and
// compared mid-cycle. Multicycle sequences run only when HAZARD_CTRL_MD_EN is defined.
module tb_hazard_ctrl;

  localparam int REG_NUM = 32;
  localparam int RW      = 5;

  typedef struct {
    int           id;
    logic [1:0]   s1;
    logic [1:0]   s2;
    logic         st;
    logic         fid;
    logic         fex;
    logic         iss;
    logic         bsy;
    logic         wbv;
    logic [RW-1:0] wbrd;
  } exp_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;
  int   cyc_id;
  exp_t exp_q[$];

  hazard_ctrl_if #(.REG_NUM(REG_NUM)) hif ();

  hazard_ctrl #(.REG_NUM(REG_NUM), .MD_LATENCY(4)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic [1:0] s1, input logic [1:0] s2, input logic st,
                              input logic fid, input logic fex, input logic iss,
                              input logic bsy, input logic wbv, input logic [RW-1:0] wbrd);
    exp_t e;
    e.id = 0; e.s1 = s1; e.s2 = s2; e.st = st; e.fid = fid; e.fex = fex;
    e.iss = iss; e.bsy = bsy; e.wbv = wbv; e.wbrd = wbrd;
    return e;
  endfunction

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk($sformatf("c%0d.rs1_sel", e.id), 32'(hif.rs1_bypass_sel), 32'(e.s1));
      chk($sformatf("c%0d.rs2_sel", e.id), 32'(hif.rs2_bypass_sel), 32'(e.s2));
      chk($sformatf("c%0d.stall_if", e.id), 32'(hif.stall_if), 32'(e.st));
      chk($sformatf("c%0d.stall_id", e.id), 32'(hif.stall_id), 32'(e.st));
      chk($sformatf("c%0d.flush_id", e.id), 32'(hif.flush_id), 32'(e.fid));
      chk($sformatf("c%0d.flush_ex", e.id), 32'(hif.flush_ex), 32'(e.fex));
      chk($sformatf("c%0d.md_issue", e.id), 32'(hif.md_issue), 32'(e.iss));
      chk($sformatf("c%0d.md_busy", e.id), 32'(hif.md_busy), 32'(e.bsy));
      chk($sformatf("c%0d.md_wb_valid", e.id), 32'(hif.md_wb_valid), 32'(e.wbv));
      chk($sformatf("c%0d.md_wb_rd", e.id), 32'(hif.md_wb_rd), 32'(e.wbrd));
    end
  end

  task automatic clr_in();
    hif.id_valid = 0; hif.id_rs1 = '0; hif.id_rs2 = '0; hif.id_rs1_used = 0;
    hif.id_rs2_used = 0; hif.id_rd = '0; hif.id_is_md = 0; hif.ex_rd = '0; hif.mm_rd = '0;
    hif.ex_wr_reg_en = 0; hif.mm_wr_reg_en = 0; hif.ex_is_load = 0; hif.mm_is_load = 0;
    hif.ex_branch_taken = 0;
  endtask

  // Queue the expectation for the inputs just driven, then advance one cycle.
  task automatic step(input exp_t e);
    e.id = cyc_id;
    cyc_id++;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic md_op(input logic [RW-1:0] rd);
    clr_in();
    hif.id_valid = 1; hif.id_is_md = 1; hif.id_rd = rd;
    hif.id_rs1 = 5'd3; hif.id_rs1_used = 1;
  endtask

  task automatic dep_rs1(input logic [RW-1:0] rs);
    clr_in();
    hif.id_valid = 1; hif.id_rs1 = rs; hif.id_rs1_used = 1; hif.id_rd = 5'd1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    n_checks = 0; n_errors = 0; cyc_id = 0;
    rst = 0;
    clr_in();
    #2 rst = 1;
    @(posedge clk); #1;
    step(mk(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0));
    rst = 0;
    step(mk(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0));

    // EX bypass, EX priority over MM, then MM-only pro / mem.
    clr_in(); hif.id_valid = 1; hif.ex_wr_reg_en = 1; hif.ex_rd = 5; hif.id_rs1 = 5; hif.id_rs1_used = 1;
    step(mk(2'b01, 2'b00, 0, 0, 0, 0, 0, 0, 0));
    hif.mm_wr_reg_en = 1; hif.mm_rd = 5;
    step(mk(2'b01, 2'b00, 0, 0, 0, 0, 0, 0, 0));
    hif.ex_wr_reg_en = 0; hif.id_rs2 = 5; hif.id_rs2_used = 1;
    step(mk(2'b10, 2'b10, 0, 0, 0, 0, 0, 0, 0));
    hif.mm_is_load = 1;
    step(mk(2'b11, 2'b11, 0, 0, 0, 0, 0, 0, 0));

    // Load-use on rs2 stalls one cycle; the load then sits in MM.
    clr_in(); hif.id_valid = 1; hif.ex_wr_reg_en = 1; hif.ex_is_load = 1; hif.ex_rd = 7;
    hif.id_rs2 = 7; hif.id_rs2_used = 1;
    step(mk(2'b00, 2'b00, 1, 0, 1, 0, 0, 0, 0));
    clr_in(); hif.id_valid = 1; hif.mm_wr_reg_en = 1; hif.mm_is_load = 1; hif.mm_rd = 7;
    hif.id_rs2 = 7; hif.id_rs2_used = 1;
    step(mk(2'b00, 2'b11, 0, 0, 0, 0, 0, 0, 0));
    // Unused source never stalls.
    clr_in(); hif.id_valid = 1; hif.ex_wr_reg_en = 1; hif.ex_is_load = 1; hif.ex_rd = 7;
    hif.id_rs2 = 7;
    step(mk(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0));

    // Register 0 neither bypasses nor stalls.
    clr_in(); hif.id_valid = 1; hif.ex_wr_reg_en = 1; hif.ex_rd = 0; hif.id_rs1_used = 1;
    step(mk(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0));
    hif.ex_is_load = 1;
    step(mk(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0));

    // Branch overrides load-use and suppresses MD issue.
    clr_in(); hif.id_valid = 1; hif.id_is_md = 1; hif.id_rd = 3; hif.ex_wr_reg_en = 1;
    hif.ex_is_load = 1; hif.ex_rd = 7; hif.id_rs2 = 7; hif.id_rs2_used = 1; hif.ex_branch_taken = 1;
    step(mk(2'b00, 2'b00, 0, 1, 1, 0, 0, 0, 0));
    clr_in();
    step(mk(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0));

`ifdef HAZARD_CTRL_MD_EN
    // RAW on an MD result: issue cycle 0, dependent stalls 1..5, WB in 5, proceeds in 6.
    md_op(5'd9);
    step(mk(2'b00, 2'b00, 0, 0, 0, 1, 0, 0, 0));
    for (int i = 1; i <= 4; i++) begin
      dep_rs1(5'd9);
      step(mk(2'b00, 2'b00, 1, 0, 1, 0, 1, 0, 5'd9));
    end
    dep_rs1(5'd9);
    step(mk(2'b00, 2'b00, 1, 0, 1, 0, 1, 1, 5'd9));
    dep_rs1(5'd9);
    step(mk(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 5'd9));

    // Structural stall, WAW stall, branch during busy, second issue after WB.
    md_op(5'd10);
    step(mk(2'b00, 2'b00, 0, 0, 0, 1, 0, 0, 5'd9));
    md_op(5'd12);
    step(mk(2'b00, 2'b00, 1, 0, 1, 0, 1, 0, 5'd10));
    clr_in(); hif.id_valid = 1; hif.id_rd = 10;
    step(mk(2'b00, 2'b00, 1, 0, 1, 0, 1, 0, 5'd10));
    md_op(5'd12); hif.ex_branch_taken = 1;
    step(mk(2'b00, 2'b00, 0, 1, 1, 0, 1, 0, 5'd10));
    md_op(5'd12);
    step(mk(2'b00, 2'b00, 1, 0, 1, 0, 1, 0, 5'd10));
    md_op(5'd12);
    step(mk(2'b00, 2'b00, 1, 0, 1, 0, 1, 1, 5'd10));
    md_op(5'd12);
    step(mk(2'b00, 2'b00, 0, 0, 0, 1, 0, 0, 5'd10));
    clr_in();
    step(mk(2'b00, 2'b00, 0, 0, 0, 0, 1, 0, 5'd12));

    // Reset in the second BUSY cycle abandons the op.
    exp_q.push_back(mk(2'b00, 2'b00, 0, 0, 0, 0, 1, 0, 5'd12));
    @(negedge clk); #1;
    rst = 1;
    #1;
    chk("rst.md_busy", 32'(hif.md_busy), 32'd0);
    chk("rst.md_wb_rd", 32'(hif.md_wb_rd), 32'd0);
    dep_rs1(5'd12);
    #1;
    chk("rst.sb_clear", 32'(hif.stall_if), 32'd0);
    @(posedge clk); #1;
    rst = 0;
    for (int i = 0; i < 6; i++) begin
      dep_rs1(5'd12);
      step(mk(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0));
    end
`else
    // Without the MD unit, MD instructions and their consumers flow freely.
    md_op(5'd9);
    step(mk(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0));
    dep_rs1(5'd9);
    step(mk(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0));
    clr_in(); hif.id_valid = 1; hif.id_rd = 9;
    step(mk(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0));
`endif

    clr_in();
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
    chk("drain", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
